// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared types and constants for the bit-serial subtractor.
//   state_t    : controller states (IDLE, RUN, DONE)
//   CARRY_INIT : carry value at reset and on acceptance; this is the "+1" of A + ~B + 1
package serial_sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic CARRY_INIT = 1'b1;

endpackage

// File: rtl/fa.sv
// fa: combinational one-bit full adder.
//   a, b : addend bits
//   cin  : carry in
//   s    : sum bit
//   cout : carry out
module fa (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_sub.sv
// serial_sub: bit-serial subtractor, D = A - B, one bit per clock, LSB first.
// A single fa cell adds A + ~B + 1; a flop carries the inter-bit carry.
// Optional feature macro: SERIAL_SUB_OVF_EN adds the signed-overflow output ovf.
//   clk   : rising-edge clock
//   n_rst : asynchronous active-low reset
//   start : request, sampled only in IDLE
//   A, B  : minuend / subtrahend, sampled on the accepting edge only
//   busy  : high whenever the controller is not IDLE
//   done  : one-cycle completion pulse
//   D     : difference (A - B) mod 2^WIDTH, held until the next completion
//   bout  : borrow out, 1 iff unsigned A < B, held
//   ovf   : signed overflow, held (SERIAL_SUB_OVF_EN only)
module serial_sub
   import serial_sub_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] D,
   output logic             bout
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [WIDTH-1:0] res;
   logic             carry;
   logic             sum;
   logic             c_out;

`ifdef SERIAL_SUB_OVF_EN
   logic             a_sign;
   logic             b_sign;
`endif

   fa u_fa (
      .a    (sa[0]),
      .b    (sb[0]),
      .cin  (carry),
      .s    (sum),
      .cout (c_out)
   );

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state <= IDLE;
         cnt   <= '0;
         sa    <= '0;
         sb    <= '0;
         res   <= '0;
         carry <= CARRY_INIT;
         busy  <= 1'b0;
         done  <= 1'b0;
         D     <= '0;
         bout  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         a_sign <= 1'b0;
         b_sign <= 1'b0;
         ovf    <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  sa    <= A;
                  sb    <= ~B;
                  carry <= CARRY_INIT;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
`ifdef SERIAL_SUB_OVF_EN
                  a_sign <= A[WIDTH-1];
                  b_sign <= B[WIDTH-1];
`endif
               end
            end
            RUN: begin
               sa    <= sa >> 1;
               sb    <= sb >> 1;
               res   <= {sum, res[WIDTH-1:1]};
               carry <= c_out;
               if (cnt == LAST) begin
                  // Final bit: publish the result built from the current sum bit.
                  D     <= {sum, res[WIDTH-1:1]};
                  bout  <= ~c_out;
                  done  <= 1'b1;
                  state <= DONE;
`ifdef SERIAL_SUB_OVF_EN
                  ovf <= (a_sign != b_sign) & (sum != a_sign);
`endif
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
